exe_muldiv_ctrl: RTL and testbench

//  Sequencer for multi-cycle MULT/MULTU/DIV/DIVU in the EXE stage. Latches operands taken

---
 rtl/exe_muldiv_ctrl.sv | 171 +++++++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer for the EXE stage.
// Owns HI/LO, runs shift-add multiply or restoring divide, stalls the pipe.
module exe_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic               dbzo_q, dbzo_d;

    logic               idle_like, busy, accept;
    logic [WIDTH-1:0]   abs_a, abs_b, a_orig;
    logic [WIDTH:0]     mul_sum, div_t, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV)
                    || (state_q == S_FIXUP);
    assign accept    = start && !flush && idle_like;
    assign stall     = busy || accept;

    assign abs_a = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    // p_q holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (p_q[0] ? b_q : {WIDTH{1'b0}})};
    assign div_t    = p_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_t - {1'b0, b_q};

    assign prod_fix = (sa_q ^ sb_q) ? -p_q : p_q;
    assign q_fix    = (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign r_fix    = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    assign a_orig   = sa_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        dbzo_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                state_d = S_IDLE;
                if (accept) begin
                    is_div_d = op[1];
                    sa_d     = op[0] && src_a[WIDTH-1];
                    sb_d     = op[0] && src_b[WIDTH-1];
                    b_d      = op[1] ? abs_b : abs_a;
                    p_d      = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                    dbz_d    = op[1] && (src_b == '0);
                    cnt_d    = '0;
                    if (!op[1])     state_d = S_MUL;
                    else if (dbz_d) state_d = S_FIXUP;
                    else            state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL)
                    p_d = {mul_sum, p_q[WIDTH-1:1]};
                else if (!div_diff[WIDTH])
                    p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                else
                    p_d = {div_t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dbz_q) begin
                    hi_d = a_orig;
                    lo_d = '1;
                end else begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end
                done_d  = 1'b1;
                dbzo_d  = dbz_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // A squash drops everything, including same-cycle MTHI/MTLO
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbzo_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            dbzo_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
            dbzo_q   <= dbzo_d;
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbzo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// tb_exe_muldiv_ctrl: directed bench with a cycle-countdown reference
// model built on plain 64-bit arithmetic.
module tb_exe_muldiv_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b, wdata;
    logic         stall, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    exe_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: rem = cycles left until the result lands in HI/LO
    int         rem = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
    logic       m_done = 0, m_dbz = 0, p_dbz;

    task automatic compute(input logic [1:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        longint x, y, q, r;
        logic [63:0] prod;
        p_dbz = 0;
        if (!o[1]) begin
            x = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
            y = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
            prod = 64'(x * y);
            p_hi = prod[63:32];
            p_lo = prod[31:0];
        end else if (b == 0) begin
            p_dbz = 1;
            p_hi = a;
            p_lo = '1;
        end else begin
            x = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
            y = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
            q = x / y;
            r = x % y;
            p_lo = q[31:0];
            p_hi = r[31:0];
        end
    endtask

    always @(posedge clk) begin
        m_done = 0;
        m_dbz = 0;
        if (rst) begin
            rem = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (rem > 0) begin
            if (flush) rem = 0;
            else begin
                rem--;
                if (rem == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_done = 1;
                    m_dbz = p_dbz;
                end
            end
        end else if (!flush) begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
                compute(op, src_a, src_b);
                rem = p_dbz ? 1 : W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 64'(stall), 64'((rem > 0) || (start && !flush)));
            chk("done", 64'(done), 64'(m_done));
            chk("dbz", 64'(div_by_zero), 64'(m_dbz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        start = 1; op = o; src_a = a; src_b = b;
        cyc();
        start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            cyc();
            n++;
        end
    endtask

    int n, cnt;

    initial begin
        rst = 1; start = 0; flush = 0; hi_we = 0; lo_we = 0;
        op = 0; src_a = 0; src_b = 0; wdata = 0;
        cyc(); cyc();
        rst = 0;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk_en = 1;

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("multu_lat", 64'(n + 1), 64'd34);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h1);

        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("divovf_lo", 64'(lo), 64'h8000_0000);
        chk("divovf_hi", 64'(hi), 64'h0);

        issue(2'b10, 32'd100, 32'd7);
        wait_done(n);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);

        issue(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done(n);

        issue(2'b10, 32'd5, 32'd0);
        wait_done(n);
        chk("dbz_lat", 64'(n + 1), 64'd2);
        chk("dbz_flag", 64'(div_by_zero), 64'h1);
        chk("dbz_hi", 64'(hi), 64'd5);
        chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        cyc();

        issue(2'b00, 32'd3, 32'd5);
        repeat (9) cyc();
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_stall", 64'(stall), 64'h0);
        cnt = 0;
        repeat (40) begin
            if (done) cnt++;
            cyc();
        end
        chk("flush_nodone", 64'(cnt), 64'h0);
        chk("flush_hi", 64'(hi), 64'd5);
        chk("flush_lo", 64'(lo), 64'hFFFF_FFFF);

        start = 1; flush = 1; op = 2'b00; src_a = 9; src_b = 9;
        cyc();
        start = 0; flush = 0;
        chk("flush_start", 64'(stall), 64'h0);

        issue(2'b00, 32'd2, 32'd3);
        wait_done(n);
        chk("b2b_first_lo", 64'(lo), 64'd6);
        issue(2'b00, 32'd4, 32'd5);
        lo_we = 1; wdata = 32'h1234;
        cyc();
        lo_we = 0;
        wait_done(n);
        chk("b2b_lat", 64'(n + 2), 64'd34);
        chk("b2b_lo", 64'(lo), 64'd20);
        cyc();
        lo_we = 1; wdata = 32'h1234;
        cyc();
        lo_we = 0;
        chk("mtlo_idle", 64'(lo), 64'h1234);

        issue(2'b11, 32'd100, 32'd3);
        repeat (19) cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("rstmid_stall", 64'(stall), 64'h0);
        chk("rstmid_hi", 64'(hi), 64'h0);
        chk("rstmid_lo", 64'(lo), 64'h0);
        cnt = 0;
        repeat (40) begin
            if (done) cnt++;
            cyc();
        end
        chk("rstmid_nodone", 64'(cnt), 64'h0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
